// File: rtl/freq_gate_pkg.sv
// rtl/freq_gate_pkg.sv - shared types, limits and state decode for the gate-time sequencer
package freq_gate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    LATCH,
    DONE
  } gate_state_t;

  // Legal synchronizer depth; fewer than two flops is not metastability-safe.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Per-state output levels, registered alongside the state itself.
  typedef struct packed {
    logic cnt_reset;
    logic cnt_load;
    logic busy;
    logic done;
    logic gate;
  } gate_flags_t;

  function automatic gate_flags_t state_flags(input gate_state_t s);
    gate_flags_t f;
    f           = '0;
    f.busy      = (s != IDLE);
    f.cnt_reset = (s == CLEAR);
    f.gate      = (s == GATE);
    f.cnt_load  = (s == LATCH);
    f.done      = (s == DONE);
    return f;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// rtl/freq_gate_ctrl_if.sv - control and count-chain signals of the gate-time sequencer
interface freq_gate_ctrl_if #(
  parameter int GATE_W = 16
);

  logic              start;
  logic              cont;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              cnt_carry;
  logic              cnt_reset;
  logic              cnt_en;
  logic              cnt_load;
  logic              busy;
  logic              done;
  logic              overflow;

  // Host and count chain side.
  modport master (
    output start, cont, abort, gate_len, cnt_carry,
    input  cnt_reset, cnt_en, cnt_load, busy, done, overflow
  );

  // Sequencer side.
  modport slave (
    input  start, cont, abort, gate_len, cnt_carry,
    output cnt_reset, cnt_en, cnt_load, busy, done, overflow
  );

endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - synchronizer and registered rising-edge detect for sig_in
module sync_edge_det
  import freq_gate_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise_q
);

  // An out-of-range depth is pulled back into the legal range.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                          SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Synchronizer chain; sync_q[STAGES-1] is the safe copy of sig_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_in};
    end
  end

  // Compare the safe level with its previous value and register the 0->1 detect,
  // so an edge reaches rise_q SYNC_STAGES+1 clock edges after sig_in moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gate-time sequencer: clear, count window, load display
module freq_gate_ctrl
  import freq_gate_pkg::*;
#(
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  freq_gate_ctrl_if.slave  bus
);

  localparam logic [GATE_W-1:0] ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  gate_state_t       state_q;
  gate_flags_t       flags_q;
  logic [GATE_W-1:0] len_q;
  logic [GATE_W-1:0] win;
  logic              overflow_q;
  logic              rise_q;
  logic [GATE_W-1:0] len_sel;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise_q (rise_q)
  );

  // A zero length would never reach win==0 cleanly; treat it as a one-cycle window.
  assign len_sel = (bus.gate_len == '0) ? ONE : bus.gate_len;

  // Sequencer: state, registered state decode, window length, window counter, overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      flags_q    <= '0;
      len_q      <= '0;
      win        <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q   <= len_sel;
            state_q <= CLEAR;
            flags_q <= state_flags(CLEAR);
          end
        end
        CLEAR: begin
          if (bus.abort) begin
            state_q <= IDLE;
            flags_q <= state_flags(IDLE);
          end else begin
            win        <= len_q - ONE;
            overflow_q <= 1'b0;
            state_q    <= GATE;
            flags_q    <= state_flags(GATE);
          end
        end
        GATE: begin
          // Abort wins over window expiry and leaves overflow as it was.
          if (bus.abort) begin
            state_q <= IDLE;
            flags_q <= state_flags(IDLE);
          end else begin
            if (bus.cnt_carry) begin
              overflow_q <= 1'b1;
            end
            if (win == '0) begin
              state_q <= LATCH;
              flags_q <= state_flags(LATCH);
            end else begin
              win <= win - ONE;
            end
          end
        end
        LATCH: begin
          state_q <= DONE;
          flags_q <= state_flags(DONE);
        end
        DONE: begin
          // Continuous mode reuses the captured length for the next window.
          if (bus.cont) begin
            state_q <= CLEAR;
            flags_q <= state_flags(CLEAR);
          end else begin
            state_q <= IDLE;
            flags_q <= state_flags(IDLE);
          end
        end
        default: begin
          state_q <= IDLE;
          flags_q <= state_flags(IDLE);
        end
      endcase
    end
  end

  assign bus.cnt_reset = flags_q.cnt_reset;
  assign bus.cnt_load  = flags_q.cnt_load;
  assign bus.busy      = flags_q.busy;
  assign bus.done      = flags_q.done;
  assign bus.overflow  = overflow_q;
  // Edges whose detect lands outside the window are dropped here.
  assign bus.cnt_en    = rise_q & flags_q.gate;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - randomized bench for freq_gate_ctrl against a timeline model
module tb_freq_gate_ctrl;

  localparam int GATE_W = 16;
  localparam int N      = 2;
  localparam int NCYC   = 4096;
  localparam int LOOK   = 110;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic sig_in = 1'b0;

  freq_gate_ctrl_if #(.GATE_W(GATE_W)) bus ();

  freq_gate_ctrl #(
    .GATE_W      (GATE_W),
    .SYNC_STAGES (N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Expected timeline, one entry per cycle (cycle k lies between clock edges k and k+1).
  bit m_rst  [NCYC];
  bit m_gate [NCYC];
  bit m_load [NCYC];
  bit m_busy [NCYC];
  bit m_done [NCYC];
  bit m_ovf  [NCYC];
  bit m_sig  [NCYC];
  int m_len = 1;

  int cyc       = 0;
  int n_tests   = 0;
  int n_fail    = 0;
  int en_seen   = 0;
  int load_seen = 0;
  int done_seen = 0;
  int done_cyc [$];
  int sig_mode  = 0;
  int hold      = 1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_from(input int x);
    for (int i = x; i < x + LOOK && i < NCYC; i++) begin
      m_rst[i]  = 1'b0;
      m_gate[i] = 1'b0;
      m_load[i] = 1'b0;
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  // One measurement starting with its clear cycle at s.
  task automatic schedule(input int s);
    m_rst[s] = 1'b1;
    for (int i = 0; i <= m_len + 2; i++) m_busy[s + i] = 1'b1;
    for (int i = 1; i <= m_len; i++) m_gate[s + i] = 1'b1;
    m_load[s + m_len + 1] = 1'b1;
    m_done[s + m_len + 2] = 1'b1;
  endtask

  // Apply the inputs held during cycle c to the expected timeline.
  task automatic model_apply(input bit rst, input bit st, input bit ab, input bit ct, input bit cy,
                             input logic [GATE_W-1:0] gl);
    int c;
    c = cyc;
    if (rst) begin
      clear_from(c);
      m_ovf[c]     = 1'b0;
      m_ovf[c + 1] = 1'b0;
    end else if (ab && (m_rst[c] || m_gate[c])) begin
      clear_from(c + 1);
      m_ovf[c + 1] = m_ovf[c];
    end else begin
      if (m_rst[c]) m_ovf[c + 1] = 1'b0;
      else if (m_gate[c] && cy) m_ovf[c + 1] = 1'b1;
      else m_ovf[c + 1] = m_ovf[c];
      if (!m_busy[c] && st) begin
        m_len = (gl == '0) ? 1 : int'(gl);
        schedule(c + 1);
      end
      if (m_done[c] && ct) schedule(c + 1);
    end
  endtask

  task automatic run_cycle(input bit rst, input bit st, input bit ab, input bit ct, input bit cy,
                           input logic [GATE_W-1:0] gl);
    @(posedge clk);
    #1;
    cyc++;
    case (sig_mode)
      1: if (cyc % 4 == 0) sig_in = ~sig_in;
      2: begin
        if (hold <= 1) begin
          sig_in = ~sig_in;
          hold   = $urandom_range(1, 5);
        end else begin
          hold--;
        end
      end
      default: sig_in = 1'b0;
    endcase
    reset         = rst;
    bus.start     = st;
    bus.abort     = ab;
    bus.cont      = ct;
    bus.cnt_carry = cy;
    bus.gate_len  = gl;
    m_sig[cyc]    = sig_in;
    model_apply(rst, st, ab, ct, cy, gl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Compare all outputs every cycle against the timeline; count observed pulses.
  always @(negedge clk) begin
    bit exp_en;
    if (cyc < NCYC - LOOK) begin
      exp_en = 1'b0;
      if (cyc >= N + 2) exp_en = m_gate[cyc] && m_sig[cyc - N - 1] && !m_sig[cyc - N - 2];
      expect_eq("outs", {bus.cnt_reset, bus.cnt_en, bus.cnt_load, bus.busy, bus.done, bus.overflow},
                {m_rst[cyc], exp_en, m_load[cyc], m_busy[cyc], m_done[cyc], m_ovf[cyc]});
      if (bus.cnt_en)   en_seen++;
      if (bus.cnt_load) load_seen++;
      if (bus.done) begin
        done_seen++;
        done_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    int s, e0, l0, d0, n;
    logic [GATE_W-1:0] gl;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0; bus.cnt_carry = 1'b0; bus.gate_len = '0;

    // reset state
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_eq("reset_outs", {bus.cnt_reset, bus.cnt_en, bus.cnt_load, bus.busy, bus.done, bus.overflow}, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(3);

    // fixed window of 100 cycles, sig_in period 8
    sig_mode = 1;
    idle(5);
    e0 = en_seen; l0 = load_seen; d0 = done_seen;
    s = cyc + 1;
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd100);
    idle(110);
    expect_eq("fix_en_n", ((en_seen - e0) >= 12) && ((en_seen - e0) <= 13), 1);
    expect_eq("fix_load_n", load_seen - l0, 1);
    expect_eq("fix_done_n", done_seen - d0, 1);
    if (done_seen - d0 == 1) expect_eq("fix_done_lat", done_cyc[$] - s, 103);
    expect_eq("fix_busy_after", bus.busy, 0);

    // zero length
    sig_mode = 2;
    d0 = done_seen;
    s = cyc + 1;
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    idle(8);
    expect_eq("zero_done_n", done_seen - d0, 1);
    if (done_seen - d0 == 1) expect_eq("zero_done_lat", done_cyc[$] - s, 4);

    // abort at GATE cycle 10 of 50
    l0 = load_seen; d0 = done_seen;
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd50);
    idle(10);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    expect_eq("abort_idle", bus.busy, 0);
    idle(60);
    expect_eq("abort_load_n", load_seen - l0, 0);
    expect_eq("abort_done_n", done_seen - d0, 0);

    // continuous mode, three windows of 20, gate_len change ignored
    d0 = done_seen;
    s = cyc + 1;
    for (int i = 0; i < 75; i++)
      run_cycle(1'b0, i == 0, 1'b0, i < 69, 1'b0, (i < 10) ? 16'd20 : 16'd5);
    expect_eq("cont_done_n", done_seen - d0, 3);
    if (done_seen - d0 == 3) begin
      n = done_cyc.size();
      expect_eq("cont_p0", done_cyc[n-3] - s, 23);
      expect_eq("cont_p1", done_cyc[n-2] - done_cyc[n-3], 23);
      expect_eq("cont_p2", done_cyc[n-1] - done_cyc[n-2], 23);
    end

    // overflow set by one carry, then cleared in the next CLEAR
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd30);
    for (int i = 1; i <= 40; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, i == 10, '0);
    expect_eq("ovf_set", bus.overflow, 1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    expect_eq("ovf_in_clear", bus.overflow, 1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    expect_eq("ovf_cleared", bus.overflow, 0);
    idle(15);

    // asynchronous reset in the middle of GATE
    sig_mode = 0;
    idle(6);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd40);
    for (int i = 1; i <= 15; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, i == 5, '0);
    expect_eq("pre_rst", {bus.busy, bus.overflow}, 2'b11);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_eq("rst_async", {bus.cnt_reset, bus.cnt_en, bus.cnt_load, bus.busy, bus.done, bus.overflow}, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    d0 = done_seen;
    s = cyc + 1;
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd12);
    idle(20);
    expect_eq("post_rst_done_n", done_seen - d0, 1);
    if (done_seen - d0 == 1) expect_eq("post_rst_lat", done_cyc[$] - s, 15);

    // randomized traffic checked cycle by cycle
    sig_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      gl = ($urandom_range(0, 5) == 0) ? '0 : GATE_W'($urandom_range(1, 40));
      run_cycle(1'b0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, gl);
    end
    idle(LOOK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
